// File: rtl/ttt_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// oversample ratio and the baud divider helper.
package ttt_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held off and
// reloaded while clear is high so the first tick lands a full period later.
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= RELOAD;
        end else if (clear || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = !clear && (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver with 16x oversampling, false-start rejection and
// stuck-low protection. Define UART_RX_PARITY_EN for an even-parity bit.
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronised 1->0 edge
// START     | confirming the start bit at mid-bit
// DATA      | sampling 8 data bits LSB first
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit, emitting rd / frame_err / parity_err
// WAIT_HIGH | bad stop seen, waiting for the line to return high
module uart_rx
    import ttt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rd,
    output logic [7:0] q,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_q;
    logic              r_rd;
    logic              r_frame_err;
    logic              r_parity_err;
    logic              r_par_bad;
    logic              w_tick;
    logic              w_clear;
    logic              w_start_edge;
    logic              w_mid;
    logic              w_rd_nxt;
    logic              w_ferr_nxt;
    logic              w_perr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_start_edge = r_rx_prev && !r_rx_sync;
    assign w_clear      = (r_state == IDLE);

    baud_tick_gen #(
        .DIV(DIV)
    ) u_baud_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(w_clear),
        .tick (w_tick)
    );

    // START samples half a bit in; later bits are a whole bit (16 ticks) apart
    assign w_mid = w_tick && ((r_state == START) ? (r_tick_cnt == MID_TICK)
                                                 : (r_tick_cnt == LAST_TICK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_edge) w_state_nxt = START;
            end
            START: begin
                if (w_mid) w_state_nxt = r_rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (w_mid && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_mid) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_mid) begin
                    if (!r_rx_sync) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end else if (r_par_bad) begin
                        w_perr_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_rd_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (r_rx_sync) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (r_state == IDLE) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_state == START && w_mid) ? '0 : r_tick_cnt + 1'b1;
            if (r_state == DATA && w_mid) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad <= 1'b0;
        end else if (r_state == IDLE) begin
            r_par_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
        end else if (r_state == PARITY && w_mid) begin
            r_par_bad <= r_rx_sync ^ (^r_shift);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= 8'h00;
            r_rd         <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rd         <= w_rd_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_parity_err <= w_perr_nxt;
            if (w_rd_nxt) r_q <= r_shift;
        end
    end

    assign rd         = r_rd;
    assign q          = r_q;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clocks per bit; a scoreboard queue holds
// the bytes sent and is checked against q on every rd pulse.
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd;
    logic [7:0] q;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    bit excl_viol = 1'b0;
    logic [7:0] sb[$];

    uart_rx #(
        .CLK_FREQ(1_600_000),
        .BAUD    (10_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .q         (q),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd) begin
                rd_cnt++;
                check("sb_nonempty_on_rd", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) check("rd_q", 32'(q), 32'(sb.pop_front()));
            end
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if ((32'(rd) + 32'(frame_err) + 32'(parity_err)) > 32'd1) excl_viol = 1'b1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        wait_clks(BIT_CLKS - 1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_v);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic pbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(pbit);
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        #2_000_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int ferr0;
        int waited;
        logic [7:0] rb;

        // reset values
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_q", 32'(q), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clks(20);

        // single good frame
        rd0 = rd_cnt; ferr0 = ferr_cnt;
        sb.push_back(8'h30);
        send_frame(8'h30, 1'b1);
        wait_clks(20);
        check("single_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("single_ferr_count", 32'(ferr_cnt - ferr0), 32'd0);
        check("single_q", 32'(q), 32'h30);
        check("single_busy_idle", 32'(busy), 32'd0);

        // back-to-back frames with no idle gap
        rd0 = rd_cnt;
        sb.push_back(8'h30);
        sb.push_back(8'h31);
        send_frame(8'h30, 1'b1);
        send_frame(8'h31, 1'b1);
        wait_clks(20);
        check("b2b_rd_count", 32'(rd_cnt - rd0), 32'd2);
        check("b2b_q_last", 32'(q), 32'h31);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // false start: 40 clocks low
        rd0 = rd_cnt; ferr0 = ferr_cnt;
        @(negedge clk);
        rx = 1'b0;
        wait_clks(40);
        rx = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < 130) begin
            @(negedge clk);
            waited++;
        end
        check("false_start_busy_clear", 32'(busy), 32'd0);
        wait_clks(200);
        check("false_start_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("false_start_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // bad stop bit, line held low
        rd0 = rd_cnt; ferr0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        wait_clks(500 - BIT_CLKS);
        check("ferr_count", 32'(ferr_cnt - ferr0), 32'd1);
        check("ferr_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("ferr_q_unchanged", 32'(q), 32'h31);
        check("ferr_busy_while_low", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clks(10);
        check("ferr_busy_after_high", 32'(busy), 32'd0);
        wait_clks(200);

        // reset in the middle of data bit 4 of 8'hA5
        rd0 = rd_cnt; ferr0 = ferr_cnt;
        rb = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        @(negedge clk);
        rx = rb[4];
        wait_clks(79);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(3);
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd", 32'(rd), 32'd0);
        reset = 1'b0;
        wait_clks(20);
        sb.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        wait_clks(20);
        check("midrst_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("midrst_ferr_count", 32'(ferr_cnt - ferr0), 32'd0);
        check("midrst_q_after", 32'(q), 32'h31);

`ifdef UART_RX_PARITY_EN
        begin
            int perr0;
            rd0 = rd_cnt; perr0 = perr_cnt;
            sb.push_back(8'h31);
            send_frame_par(8'h31, 1'b1);
            wait_clks(20);
            check("par_good_rd", 32'(rd_cnt - rd0), 32'd1);
            check("par_good_perr", 32'(perr_cnt - perr0), 32'd0);
            rd0 = rd_cnt; perr0 = perr_cnt;
            send_frame_par(8'h31, 1'b0);
            wait_clks(20);
            check("par_bad_perr", 32'(perr_cnt - perr0), 32'd1);
            check("par_bad_no_rd", 32'(rd_cnt - rd0), 32'd0);
            check("par_bad_q", 32'(q), 32'h31);
        end
`endif

        // random back-to-back bytes
        rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            sb.push_back(rb);
            send_frame(rb, 1'b1);
        end
        wait_clks(20);
        check("rand_rd_count", 32'(rd_cnt - rd0), 32'd4);
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        check("pulses_exclusive", 32'(excl_viol), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
